// File: rtl/alu_issue_unit.sv
// ============================================================================
// Module      : alu_issue_unit
// Description : Issue/decode front end for a combinational ALU. Accepts one
//               instruction at a time, reads operands from a local register
//               file, drives the ALU, then writes back the result and PSR.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_issue_unit #(
    parameter int NREGS = 16,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [15:0]      instr,
    output logic [7:0]       alu_opcode,
    output logic [WIDTH-1:0] alu_src,
    output logic [WIDTH-1:0] alu_dst,
    output logic [WIDTH-1:0] alu_imm,
    output logic             alu_cin,
    input  logic [WIDTH-1:0] alu_c,
    input  logic [4:0]       alu_flags,
    output logic [4:0]       psr,
    output logic             done,
    output logic             illegal,
    input  logic             ext_we,
    input  logic [3:0]       ext_waddr,
    input  logic [WIDTH-1:0] ext_wdata,
    input  logic [3:0]       dbg_raddr,
    output logic [WIDTH-1:0] dbg_rdata
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_WB     = 2'd3
    } state_t;

    localparam logic [7:0] OPC_CMP = 8'h0B;

    state_t             state_q, state_d;
    logic [15:0]        instr_q, instr_d;
    logic [WIDTH-1:0]   regs_q [NREGS];
    logic [WIDTH-1:0]   regs_d [NREGS];
    logic [4:0]         psr_q, psr_d;
    logic [7:0]         alu_opcode_q, alu_opcode_d;
    logic [WIDTH-1:0]   alu_src_q, alu_src_d;
    logic [WIDTH-1:0]   alu_dst_q, alu_dst_d;
    logic [WIDTH-1:0]   alu_imm_q, alu_imm_d;
    logic               alu_cin_q, alu_cin_d;
    logic               done_q, done_d;
    logic               illegal_q, illegal_d;

    function automatic logic is_legal(input logic [15:0] w);
        logic [3:0] op;
        logic [3:0] ext;
        op  = w[15:12];
        ext = w[7:4];
        case (op)
            4'h0:                         is_legal = (ext == 4'h1) || (ext == 4'h2) ||
                                                     (ext == 4'h3) || (ext == 4'h5) ||
                                                     (ext == 4'h6) || (ext == 4'h9) ||
                                                     (ext == 4'hB);
            4'h8:                         is_legal = (ext == 4'h4) || (ext == 4'hC);
            4'h1, 4'h2, 4'h3, 4'h5, 4'h6: is_legal = 1'b1;
            default:                      is_legal = 1'b0;
        endcase
    endfunction

    // Carry-consuming operations pick up the current PSR carry as c_in.
    function automatic logic uses_carry(input logic [7:0] opc);
        case (opc)
            8'h05, 8'h06, 8'h09, 8'h0B, 8'h50, 8'h60: uses_carry = 1'b1;
            default:                                   uses_carry = 1'b0;
        endcase
    endfunction

    always_comb begin
        logic [3:0]  op;
        logic [7:0]  opc;
        state_d      = state_q;
        instr_d      = instr_q;
        regs_d       = regs_q;
        psr_d        = psr_q;
        alu_opcode_d = alu_opcode_q;
        alu_src_d    = alu_src_q;
        alu_dst_d    = alu_dst_q;
        alu_imm_d    = alu_imm_q;
        alu_cin_d    = alu_cin_q;
        done_d       = 1'b0;
        illegal_d    = 1'b0;
        op           = instr_q[15:12];
        opc          = 8'h00;

        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    instr_d   = instr;
                    state_d   = S_DECODE;
                    // Flag is raised for the DECODE cycle of an unsupported word.
                    illegal_d = !is_legal(instr);
                end else if (ext_we) begin
                    regs_d[ext_waddr] = ext_wdata;
                end
            end
            S_DECODE: begin
                if (is_legal(instr_q)) begin
                    alu_dst_d = regs_q[instr_q[11:8]];
                    if (op == 4'h0 || op == 4'h8) begin
                        opc       = {op, instr_q[7:4]};
                        alu_src_d = regs_q[instr_q[3:0]];
                        alu_imm_d = '0;
                    end else begin
                        opc       = {op, 4'h0};
                        alu_src_d = '0;
                        if (op == 4'h5 || op == 4'h6)
                            alu_imm_d = {{(WIDTH-8){instr_q[7]}}, instr_q[7:0]};
                        else
                            alu_imm_d = {{(WIDTH-8){1'b0}}, instr_q[7:0]};
                    end
                    alu_opcode_d = opc;
                    alu_cin_d    = uses_carry(opc) ? psr_q[3] : 1'b0;
                    state_d      = S_EXEC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_EXEC: begin
                done_d  = 1'b1;
                state_d = S_WB;
            end
            S_WB: begin
                if (alu_opcode_q != OPC_CMP)
                    regs_d[instr_q[11:8]] = alu_c;
                psr_d   = alu_flags;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            instr_q      <= '0;
            psr_q        <= '0;
            alu_opcode_q <= '0;
            alu_src_q    <= '0;
            alu_dst_q    <= '0;
            alu_imm_q    <= '0;
            alu_cin_q    <= 1'b0;
            done_q       <= 1'b0;
            illegal_q    <= 1'b0;
            for (int i = 0; i < NREGS; i++)
                regs_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            instr_q      <= instr_d;
            psr_q        <= psr_d;
            alu_opcode_q <= alu_opcode_d;
            alu_src_q    <= alu_src_d;
            alu_dst_q    <= alu_dst_d;
            alu_imm_q    <= alu_imm_d;
            alu_cin_q    <= alu_cin_d;
            done_q       <= done_d;
            illegal_q    <= illegal_d;
            regs_q       <= regs_d;
        end
    end

    assign instr_ready = (state_q == S_IDLE);
    assign alu_opcode  = alu_opcode_q;
    assign alu_src     = alu_src_q;
    assign alu_dst     = alu_dst_q;
    assign alu_imm     = alu_imm_q;
    assign alu_cin     = alu_cin_q;
    assign psr         = psr_q;
    assign done        = done_q;
    assign illegal     = illegal_q;
    assign dbg_rdata   = regs_q[dbg_raddr];

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_unit.sv
// ============================================================================
// Module      : tb_alu_issue_unit
// Description : Directed and random checks of alu_issue_unit against a
//               behavioural model, with a stand-in combinational ALU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_issue_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [7:0]  alu_opcode;
    logic [15:0] alu_src, alu_dst, alu_imm;
    logic        alu_cin;
    logic [15:0] alu_c;
    logic [4:0]  alu_flags;
    logic [4:0]  psr;
    logic        done, illegal;
    logic        ext_we;
    logic [3:0]  ext_waddr;
    logic [15:0] ext_wdata;
    logic [3:0]  dbg_raddr;
    logic [15:0] dbg_rdata;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_regs [16];
    logic [4:0]  m_psr;

    always #5 clk = ~clk;

    alu_issue_unit #(.NREGS(16), .WIDTH(16)) dut (
        .clk(clk), .reset(reset),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .alu_opcode(alu_opcode), .alu_src(alu_src), .alu_dst(alu_dst),
        .alu_imm(alu_imm), .alu_cin(alu_cin),
        .alu_c(alu_c), .alu_flags(alu_flags),
        .psr(psr), .done(done), .illegal(illegal),
        .ext_we(ext_we), .ext_waddr(ext_waddr), .ext_wdata(ext_wdata),
        .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
    );

    // Stand-in ALU: flags {Z, C, F, L, N}; N marks dst > src (signed) on CMP.
    function automatic void alu_model(input logic [7:0] opc, input logic [15:0] a,
                                      input logic [15:0] src, input logic [15:0] imm,
                                      input logic cin, output logic [15:0] c,
                                      output logic [4:0] fl);
        logic [15:0] b;
        logic [16:0] s;
        logic cy, ov, n;
        b  = (opc[3:0] == 4'h0) ? imm : src;
        s  = '0; cy = 1'b0; ov = 1'b0; n = 1'b0;
        case (opc)
            8'h05, 8'h06, 8'h50, 8'h60: begin
                s  = {1'b0, a} + {1'b0, b} + {16'b0, cin};
                cy = s[16];
                ov = (a[15] == b[15]) && (s[15] != a[15]);
            end
            8'h09, 8'h0B: begin
                s  = {1'b0, a} - {1'b0, b} - {16'b0, cin};
                cy = s[16];
                ov = (a[15] != b[15]) && (s[15] != a[15]);
                n  = (opc == 8'h0B) && ($signed(a) > $signed(b));
            end
            8'h01, 8'h10: s = {1'b0, a & b};
            8'h02, 8'h20: s = {1'b0, a | b};
            8'h03, 8'h30: s = {1'b0, a ^ b};
            8'h84:        s = {1'b0, a << b[3:0]};
            8'h8C:        s = {1'b0, a >> b[3:0]};
            default:      s = '0;
        endcase
        c  = s[15:0];
        fl = {(c == 16'h0), cy, ov, 1'b0, n};
    endfunction

    always_comb begin
        alu_c     = '0;
        alu_flags = '0;
        alu_model(alu_opcode, alu_dst, alu_src, alu_imm, alu_cin, alu_c, alu_flags);
    end

    // Instruction-set view: which words are legal and what they present to the ALU.
    function automatic bit ref_decode(input logic [15:0] w, output logic [7:0] opc,
                                      output bit imm_form, output logic [15:0] imm);
        int op, ext;
        op  = int'(w[15:12]);
        ext = int'(w[7:4]);
        imm_form = 0;
        imm = 16'h0;
        opc = 8'h00;
        if (op == 0 && (ext inside {1, 2, 3, 5, 6, 9, 11})) begin
            opc = 8'(op * 16 + ext);
            return 1;
        end
        if (op == 8 && (ext inside {4, 12})) begin
            opc = 8'(op * 16 + ext);
            return 1;
        end
        if (op inside {1, 2, 3, 5, 6}) begin
            opc = 8'(op * 16);
            imm_form = 1;
            if (op >= 5) imm = 16'($signed(w[7:0]));
            else         imm = 16'(w[7:0]);
            return 1;
        end
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ext_write(input logic [3:0] a, input logic [15:0] d);
        chk("ready_before_ext", 32'(instr_ready), 1);
        ext_we = 1'b1; ext_waddr = a; ext_wdata = d;
        @(posedge clk); #1;
        ext_we = 1'b0;
        m_regs[a] = d;
    endtask

    task automatic issue(input logic [15:0] w, input bit hold, input logic [15:0] next_w);
        bit          legal, imm_form;
        logic [7:0]  opc;
        logic [15:0] imm, src, dst, c;
        logic [4:0]  fl;
        logic        cin;
        logic [3:0]  rd, rs, other;
        legal = ref_decode(w, opc, imm_form, imm);
        rd    = w[11:8];
        rs    = w[3:0];
        dst   = m_regs[rd];
        src   = imm_form ? 16'h0 : m_regs[rs];
        cin   = (opc inside {8'h05, 8'h06, 8'h09, 8'h0B, 8'h50, 8'h60}) ? m_psr[3] : 1'b0;

        chk("ready_idle", 32'(instr_ready), 1);
        instr = w; instr_valid = 1'b1;
        @(posedge clk); #1;
        if (hold) instr = next_w;
        else begin instr_valid = 1'b0; instr = 16'($urandom); end
        ext_we = 1'b1; ext_waddr = 4'($urandom); ext_wdata = 16'($urandom);
        chk("illegal_in_decode", 32'(illegal), 32'(!legal));
        chk("ready_decode", 32'(instr_ready), 0);
        if (!legal) begin
            @(posedge clk); #1;
            ext_we = 1'b0;
            chk("ready_after_illegal", 32'(instr_ready), 1);
            chk("illegal_one_cycle", 32'(illegal), 0);
            chk("no_done_illegal", 32'(done), 0);
            chk("psr_kept_illegal", 32'(psr), 32'(m_psr));
            dbg_raddr = rd; #1;
            chk("reg_kept_illegal", 32'(dbg_rdata), 32'(m_regs[rd]));
            return;
        end
        @(posedge clk); #1;
        chk("exec_opcode", 32'(alu_opcode), 32'(opc));
        chk("exec_dst", 32'(alu_dst), 32'(dst));
        chk("exec_src", 32'(alu_src), 32'(src));
        chk("exec_imm", 32'(alu_imm), 32'(imm));
        chk("exec_cin", 32'(alu_cin), 32'(cin));
        chk("exec_no_done", 32'(done), 0);
        chk("ready_exec", 32'(instr_ready), 0);
        @(posedge clk); #1;
        chk("wb_done", 32'(done), 1);
        chk("ready_wb", 32'(instr_ready), 0);
        @(posedge clk); #1;
        ext_we = 1'b0;
        alu_model(opc, dst, src, imm, cin, c, fl);
        if (opc != 8'h0B) m_regs[rd] = c;
        m_psr = fl;
        chk("done_one_cycle", 32'(done), 0);
        chk("psr_after_wb", 32'(psr), 32'(m_psr));
        chk("ready_after_wb", 32'(instr_ready), 1);
        dbg_raddr = rd; #1;
        chk("rdest_after_wb", 32'(dbg_rdata), 32'(m_regs[rd]));
        other = 4'($urandom);
        dbg_raddr = other; #1;
        chk("other_reg_after_wb", 32'(dbg_rdata), 32'(m_regs[other]));
    endtask

    initial begin
        logic [15:0] w;
        logic [3:0]  ext_tab [7];
        logic [3:0]  imm_tab [5];
        ext_tab = '{4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h9, 4'hB};
        imm_tab = '{4'h1, 4'h2, 4'h3, 4'h5, 4'h6};

        reset = 1'b1; instr_valid = 1'b0; instr = '0;
        ext_we = 1'b0; ext_waddr = '0; ext_wdata = '0; dbg_raddr = '0;
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        m_psr = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;

        chk("reset_ready", 32'(instr_ready), 1);
        chk("reset_psr", 32'(psr), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_illegal", 32'(illegal), 0);
        chk("reset_opcode", 32'(alu_opcode), 0);
        chk("reset_src", 32'(alu_src), 0);
        chk("reset_dst", 32'(alu_dst), 0);
        chk("reset_imm", 32'(alu_imm), 0);
        chk("reset_cin", 32'(alu_cin), 0);
        for (int i = 0; i < 16; i++) begin
            dbg_raddr = 4'(i); #1;
            chk("reset_reg", 32'(dbg_rdata), 0);
        end

        // ADD with signed overflow
        ext_write(4'h1, 16'h7FFF);
        ext_write(4'h2, 16'h7FFF);
        issue(16'h0152, 0, 16'h0);
        chk("add_ovf_psr", 32'(psr), 32'(5'b00100));
        dbg_raddr = 4'h1; #1;
        chk("add_ovf_r1", 32'(dbg_rdata), 32'h0000FFFE);

        // CMP: flags only
        ext_write(4'h3, 16'h0001);
        ext_write(4'h4, 16'h0000);
        issue(16'h03B4, 0, 16'h0);
        chk("cmp_psr", 32'(psr), 32'(5'b00001));
        dbg_raddr = 4'h3; #1;
        chk("cmp_r3_kept", 32'(dbg_rdata), 32'h00000001);

        issue(16'h1500, 0, 16'h0);
        issue(16'h56FE, 0, 16'h0);
        issue(16'h2780, 0, 16'h0);

        issue(16'h01F2, 0, 16'h0);

        // ext write while instr_valid is high must be dropped
        ext_we = 1'b1; ext_waddr = 4'h9; ext_wdata = 16'hBEEF;
        issue(16'h01F2, 0, 16'h0);
        dbg_raddr = 4'h9; #1;
        chk("ext_we_with_valid", 32'(dbg_rdata), 32'(m_regs[9]));

        // Carry chain, then back-to-back issue with valid held
        ext_write(4'h1, 16'hFFFF);
        ext_write(4'h2, 16'h0001);
        issue(16'h0162, 0, 16'h0);
        chk("addu_carry_set", 32'(psr[3]), 1);
        ext_write(4'h1, 16'h00F0);
        issue(16'h0162, 1, 16'h0112);
        issue(16'h0112, 0, 16'h0);

        // Random traffic
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0)
                ext_write(4'($urandom), 16'($urandom));
            w = 16'($urandom);
            case ($urandom_range(0, 3))
                0: ;
                1: begin w[15:12] = 4'h0; w[7:4] = ext_tab[$urandom_range(0, 6)]; end
                2: begin w[15:12] = 4'h8; w[7:4] = ($urandom_range(0, 1) == 1) ? 4'h4 : 4'hC; end
                default: w[15:12] = imm_tab[$urandom_range(0, 4)];
            endcase
            issue(w, 0, 16'h0);
        end

        // Reset while an ADD is in EXEC
        ext_write(4'h1, 16'h1234);
        ext_write(4'h2, 16'h0001);
        instr = 16'h0152; instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1; #1;
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        m_psr = '0;
        chk("rst_exec_done", 32'(done), 0);
        chk("rst_exec_psr", 32'(psr), 32'(m_psr));
        dbg_raddr = 4'h1; #1;
        chk("rst_exec_r1", 32'(dbg_rdata), 32'(m_regs[1]));
        #2 reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("rst_exec_no_done", 32'(done), 0);
        end
        chk("rst_exec_ready", 32'(instr_ready), 1);
        dbg_raddr = 4'h1; #1;
        chk("rst_exec_r1_after", 32'(dbg_rdata), 32'(m_regs[1]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
